// File: rtl/fp16_pkg.sv
// Shared binary16 constants, rounding-mode encodings and the normalize->round
// stage payload used by the fp16 round/pack pipeline.
package fp16_pkg;
    localparam int NSIG_D = 10;
    localparam int EXPW_D = 7;
    localparam int BIAS   = 15;
    localparam int EMAX   = 30;
    localparam int SIGW   = NSIG_D + 1;  // significand incl. hidden bit
    localparam int S1_EW  = 8;           // biased exponent after clamping at 0
    localparam int STAGES = 2;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RNA = 3'b100;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [14:0] MAXF = 15'h7BFF;
    localparam logic [14:0] INF  = 15'h7C00;

    typedef struct packed {
        logic             sign;
        logic [S1_EW-1:0] exp;
        logic [SIGW-1:0]  sig;
        logic             guard;
        logic             sticky;
        logic [2:0]       rm;
        logic             nan;
        logic             inf;
        logic             zero;
    } s1_t;
endpackage

// File: rtl/fp16_round_inc.sv
// Rounding increment decision from mode, sign, lsb, guard and sticky.
// Unknown mode encodings behave as round-to-nearest-even.
module fp16_round_inc
    import fp16_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       inc
);
    always_comb begin
        inc = guard & (sticky | lsb);
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RNA:  inc = guard;
            default: ;
        endcase
    end
endmodule

// File: rtl/fp16_round_pack.sv
// Two-stage normalize/round/pack for the binary16 multiplier with valid/ready.
// Define EXC_FLAGS_EN to add the registered out_flags {overflow, underflow, inexact}.
module fp16_round_pack #(
    parameter int NSIG = fp16_pkg::NSIG_D,
    parameter int EXPW = fp16_pkg::EXPW_D,
    parameter int BIAS = fp16_pkg::BIAS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic signed [EXPW-1:0] in_exp,
    input  logic [2*NSIG+1:0]      in_sig,
    input  logic [2:0]             in_rm,
    input  logic                   in_nan,
    input  logic                   in_inf,
    input  logic                   in_zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_result
`ifdef EXC_FLAGS_EN
    ,
    output logic [2:0]             out_flags
`endif
);
    import fp16_pkg::*;

    localparam int PW = 2*NSIG + 2;
    localparam int EW = EXPW + 3;
    localparam logic signed [EW-1:0] E_ONE  = 1;
    localparam logic signed [EW-1:0] SH_MAX = SIGW + 1;

    logic [STAGES:1] vld_pipe;
    logic            adv1, adv2;
    s1_t             s1_d, s1_q;

    assign adv2      = ~vld_pipe[2] | out_ready;
    assign adv1      = ~vld_pipe[1] | adv2;
    assign in_ready  = adv1;
    assign out_valid = vld_pipe[2];

    // Stage 1: normalize the product, then denormalize into the subnormal range.
    logic [NSIG-1:0]      frac;
    logic                 grd, stk;
    logic signed [EW-1:0] e_full, sh_full;
    logic [3:0]           sh;
    logic [SIGW:0]        vec;
    logic [2*SIGW+1:0]    wide;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.rm   = (in_rm > RM_RNA) ? RM_RNE : in_rm;
        s1_d.nan  = in_nan;
        s1_d.inf  = in_inf;
        s1_d.zero = in_zero;
        if (in_sig[PW-1]) begin
            frac = in_sig[PW-2 -: NSIG];
            grd  = in_sig[NSIG];
            stk  = |in_sig[NSIG-1:0];
        end else begin
            frac = in_sig[PW-3 -: NSIG];
            grd  = in_sig[NSIG-1];
            stk  = |in_sig[NSIG-2:0];
        end
        e_full  = EW'(in_exp) + EW'(in_sig[PW-1]) + EW'(BIAS);
        vec     = {1'b1, frac, grd};
        sh_full = E_ONE - e_full;
        sh      = '0;
        wide    = '0;
        if (e_full < E_ONE) begin
            // Shifts past the whole significand leave only sticky behind.
            sh          = (sh_full > SH_MAX) ? 4'(SIGW + 1) : sh_full[3:0];
            wide        = {vec, {(SIGW+1){1'b0}}} >> sh;
            s1_d.exp    = '0;
            s1_d.sig    = wide[2*SIGW+1 -: SIGW];
            s1_d.guard  = wide[SIGW+1];
            s1_d.sticky = stk | (|wide[SIGW:0]);
        end else begin
            s1_d.exp    = e_full[S1_EW-1:0];
            s1_d.sig    = {1'b1, frac};
            s1_d.guard  = grd;
            s1_d.sticky = stk;
        end
    end

    // Stage 2: round, renormalize on carry, saturate by mode, apply specials.
    logic             inc, ovf;
    logic [SIGW:0]    m;
    logic [S1_EW:0]   e_r;
    logic [SIGW-2:0]  frac_r;
    logic [15:0]      ov_res, res;

    fp16_round_inc u_inc (
        .rm     (s1_q.rm),
        .sign   (s1_q.sign),
        .lsb    (s1_q.sig[0]),
        .guard  (s1_q.guard),
        .sticky (s1_q.sticky),
        .inc    (inc)
    );

    always_comb begin
        m = {1'b0, s1_q.sig} + {{SIGW{1'b0}}, inc};
        if (s1_q.exp == '0) begin
            // A subnormal reaching 0x400 lands on the minimum normal encoding.
            e_r    = {{S1_EW{1'b0}}, m[SIGW-1]};
            frac_r = m[SIGW-2:0];
        end else if (m[SIGW]) begin
            e_r    = {1'b0, s1_q.exp} + {{S1_EW{1'b0}}, 1'b1};
            frac_r = m[SIGW-1:1];
        end else begin
            e_r    = {1'b0, s1_q.exp};
            frac_r = m[SIGW-2:0];
        end
        ovf = e_r > (S1_EW+1)'(EMAX);
        case (s1_q.rm)
            RM_RTZ:  ov_res = {s1_q.sign, MAXF};
            RM_RUP:  ov_res = s1_q.sign ? {1'b1, MAXF} : {1'b0, INF};
            RM_RDN:  ov_res = s1_q.sign ? {1'b1, INF}  : {1'b0, MAXF};
            default: ov_res = {s1_q.sign, INF};
        endcase
        if (s1_q.nan)       res = QNAN;
        else if (s1_q.inf)  res = {s1_q.sign, INF};
        else if (s1_q.zero) res = {s1_q.sign, 15'h0};
        else if (ovf)       res = ov_res;
        else                res = {s1_q.sign, e_r[4:0], frac_r};
    end

`ifdef EXC_FLAGS_EN
    logic       special, inexact;
    logic [2:0] flags_d;
    assign special = s1_q.nan | s1_q.inf | s1_q.zero;
    assign inexact = ~special & (s1_q.guard | s1_q.sticky);
    assign flags_d = {~special & ovf, inexact & (s1_q.exp == '0), inexact};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            s1_q       <= '0;
            out_result <= '0;
`ifdef EXC_FLAGS_EN
            out_flags  <= '0;
`endif
        end else begin
            if (adv1) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_result <= res;
`ifdef EXC_FLAGS_EN
                    out_flags  <= flags_d;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_fp16_round_pack.sv
// Self-checking bench for fp16_round_pack: directed cases plus random traffic
// scored against an arithmetic binary16 rounding model.
module tb_fp16_round_pack;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_sign;
    logic signed [6:0] in_exp;
    logic [21:0]       in_sig;
    logic [2:0]        in_rm;
    logic              in_nan, in_inf, in_zero;
    logic              out_valid, out_ready;
    logic [15:0]       out_result;
`ifdef EXC_FLAGS_EN
    logic [2:0]        out_flags;
`endif

    fp16_round_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sig     (in_sig),
        .in_rm      (in_rm),
        .in_nan     (in_nan),
        .in_inf     (in_inf),
        .in_zero    (in_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef EXC_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          cyc = 0, n_acc = 0, n_out = 0, last_lat = 0;
    logic [18:0] exp_q[$];
    int          acc_cyc_q[$];
    logic [15:0] last_out, prev_res;
    logic [2:0]  last_flags;
    logic        prev_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: quantize the exact product to the binary16 grid of its binade
    // (grid 2^-24 below the normal range), then use the monotone encoding.
    function automatic logic [18:0] model(input logic s, input logic signed [6:0] ex,
                                          input logic [21:0] sg, input logic [2:0] rm,
                                          input logic nan, input logic inf, input logic zero);
        int              x, q, k;
        longint unsigned n, rem, half;
        longint          bits;
        logic            up, ovf;
        logic [15:0]     r;
        if (nan)  return {3'b000, 16'h7E00};
        if (inf)  return {3'b000, s, 15'h7C00};
        if (zero) return {3'b000, s, 15'h0000};
        x    = int'(ex) + (sg[21] ? 1 : 0);
        q    = ((x > -14) ? x : -14) - 10;
        k    = q - int'(ex) + 20;
        n    = 64'(sg) >> k;
        rem  = 64'(sg) - (n << k);
        half = 64'd1 << (k - 1);
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = s && rem != 0;
            3'd3:    up = !s && rem != 0;
            3'd4:    up = rem >= half;
            default: up = rem > half || (rem == half && n[0]);
        endcase
        bits = longint'(q + 24) * 1024 + longint'(n) + (up ? 1 : 0);
        ovf  = bits >= 64'sh7C00;
        if (ovf) begin
            case (rm)
                3'd1:    r = {s, 15'h7BFF};
                3'd2:    r = s ? 16'hFC00 : 16'h7BFF;
                3'd3:    r = s ? 16'hFBFF : 16'h7C00;
                default: r = {s, 15'h7C00};
            endcase
        end else begin
            r = {s, bits[14:0]};
        end
        return {ovf, (x < -14) && rem != 0, rem != 0, r};
    endfunction

    // One cycle: sample #1 after the negedge, score transfers, advance to next negedge.
    task automatic tick();
        logic [18:0] e;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_result), 32'(prev_res));
        end
        if (out_valid && out_ready) begin
            chk("out_has_input", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result", 32'(out_result), 32'(e[15:0]));
`ifdef EXC_FLAGS_EN
                chk("flags", 32'(out_flags), 32'(e[18:16]));
                last_flags = out_flags;
`endif
                last_lat = cyc - acc_cyc_q.pop_front();
            end
            last_out = out_result;
            n_out++;
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_sign, in_exp, in_sig, in_rm, in_nan, in_inf, in_zero));
            acc_cyc_q.push_back(cyc);
            n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        @(negedge clk);
        cyc++;
    endtask

    task automatic load(input logic s, input int e, input logic [21:0] sg,
                        input logic [2:0] rm, input logic [2:0] spc);
        in_sign = s; in_exp = 7'(e); in_sig = sg; in_rm = rm;
        {in_nan, in_inf, in_zero} = spc;
    endtask

    task automatic send(input logic s, input int e, input logic [21:0] sg,
                        input logic [2:0] rm, input logic [2:0] spc);
        int a0 = n_acc;
        load(s, e, sg, rm, spc);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc == a0; i++) tick();
        in_valid = 1'b0;
        if (n_acc == a0) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    task automatic dir(input string tag, input logic s, input int e, input logic [21:0] sg,
                       input logic [2:0] rm, input logic [2:0] spc, input logic [15:0] res);
        send(s, e, sg, rm, spc);
        drain();
        chk(tag, 32'(last_out), 32'(res));
    endtask

    task automatic rand_in();
        int e;
        e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 127)) - 64
                                        : int'($urandom_range(0, 48)) - 30;
        load(1'($urandom), e, 22'($urandom_range(22'h100000, 22'h3FFFFF)), 3'($urandom),
             {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 15) == 0)});
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, o0, idx;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        load(1'b0, 0, 22'h100000, 3'd0, 3'b000);
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_result", 32'(out_result), 0);
        @(negedge clk);
        rst_n = 1'b1;

        dir("basic_1p0", 0, 0, 22'h100000, 3'd0, 3'b000, 16'h3C00);
        chk("latency", 32'(last_lat), 2);
        dir("basic_carry", 0, 0, 22'h240000, 3'd0, 3'b000, 16'h4080);
        dir("tie_rne", 0, 0, 22'h100200, 3'd0, 3'b000, 16'h3C00);
        dir("tie_rtz", 0, 0, 22'h100200, 3'd1, 3'b000, 16'h3C00);
        dir("tie_rdn", 0, 0, 22'h100200, 3'd2, 3'b000, 16'h3C00);
        dir("tie_rup", 0, 0, 22'h100200, 3'd3, 3'b000, 16'h3C01);
        dir("tie_rna", 0, 0, 22'h100200, 3'd4, 3'b000, 16'h3C01);
        dir("tie_rne_odd", 0, 0, 22'h100600, 3'd0, 3'b000, 16'h3C02);
        dir("tie_rm7", 0, 0, 22'h100600, 3'd7, 3'b000, 16'h3C02);
        dir("ovf_rne", 0, 16, 22'h100000, 3'd0, 3'b000, 16'h7C00);
        dir("ovf_rtz", 0, 16, 22'h100000, 3'd1, 3'b000, 16'h7BFF);
        dir("ovf_rdn_pos", 0, 16, 22'h100000, 3'd2, 3'b000, 16'h7BFF);
        dir("ovf_rup_neg", 1, 16, 22'h100000, 3'd3, 3'b000, 16'hFBFF);
        dir("ovf_rdn_neg", 1, 16, 22'h100000, 3'd2, 3'b000, 16'hFC00);
`ifdef EXC_FLAGS_EN
        chk("flags_ovf_exact", 32'(last_flags), 32'b100);
        dir("ovf_inexact", 0, 16, 22'h100001, 3'd0, 3'b000, 16'h7C00);
        chk("flags_ovf_inexact", 32'(last_flags), 32'b101);
`endif
        dir("sub_min", 0, -24, 22'h100000, 3'd0, 3'b000, 16'h0001);
        dir("sub_half_rne", 0, -25, 22'h100000, 3'd0, 3'b000, 16'h0000);
        dir("sub_half_rup", 0, -25, 22'h100000, 3'd3, 3'b000, 16'h0001);
        dir("sub_0200", 0, -15, 22'h100000, 3'd0, 3'b000, 16'h0200);
        dir("sub_to_norm", 0, -16, 22'h3FFFFF, 3'd0, 3'b000, 16'h0400);
        dir("sub_deep", 0, -64, 22'h3FFFFF, 3'd3, 3'b000, 16'h0001);
        dir("nan_over_inf", 1, 3, 22'h123456, 3'd0, 3'b110, 16'h7E00);
        dir("inf_neg", 1, 3, 22'h100000, 3'd0, 3'b010, 16'hFC00);
        dir("zero_neg", 1, 3, 22'h100000, 3'd0, 3'b001, 16'h8000);

        // Backpressure: five stalled cycles offering three inputs.
        a0 = n_acc; o0 = n_out; idx = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        load(1'b0, 0, 22'h100000, 3'd0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (n_acc - a0 > idx) begin
                idx++;
                if (idx < 3) in_exp = 7'(idx); else in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 32'(n_acc - a0), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && idx < 3; i++) begin
            tick();
            if (n_acc - a0 > idx) begin
                idx++;
                if (idx < 3) in_exp = 7'(idx); else in_valid = 1'b0;
            end
        end
        drain();
        chk("bp_outputs", 32'(n_out - o0), 3);
        chk("bp_last", 32'(last_out), 32'h4400);

        // Asynchronous reset in the middle of traffic.
        in_valid = 1'b1; out_ready = 1'b1;
        load(1'b0, 1, 22'h180000, 3'd0, 3'b000);
        tick(); tick(); tick();
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_result", 32'(out_result), 0);
        exp_q.delete(); acc_cyc_q.delete();
        prev_stall = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        dir("post_reset", 1, -1, 22'h100000, 3'd0, 3'b000, 16'hB800);

        // Random traffic with random backpressure.
        for (int i = 0; i < 800; i++) begin
            rand_in();
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
